// File: rtl/kmap_sweep_ctrl.sv
// rtl/kmap_sweep_ctrl.sv - exhaustive input sweep and truth-table checker for small combinational functions
module kmap_sweep_ctrl #(
  parameter int                      N_IN      = 3,
  parameter int                      SETTLE    = 0,
  parameter logic [(1<<N_IN)-1:0]    REF_TABLE = 8'hFE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [N_IN-1:0]   vec_out,
  input  logic              dut_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [N_IN:0]     err_count,
  output logic [N_IN-1:0]   first_err_idx,
  output logic              first_err_valid
);

  localparam logic [N_IN-1:0] LAST_VEC = {N_IN{1'b1}};
  localparam logic [3:0]      SETTLE_C = 4'(SETTLE);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] hold_cnt;
  logic       go;
  logic       mismatch;
  logic       running;

  // With no settle time the WAIT state is skipped entirely.
  function automatic state_t vec_entry_state();
    return (SETTLE == 0) ? S_CHECK : S_WAIT;
  endfunction

  assign running  = (state == S_WAIT) || (state == S_CHECK);
  // abort beats start even in IDLE/DONE, where abort otherwise does nothing.
  assign go       = start && !abort && !running;
  assign mismatch = (dut_out != REF_TABLE[vec_out]);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (go) state_nxt = vec_entry_state();
      S_WAIT: begin
        if (abort)              state_nxt = S_IDLE;
        else if (hold_cnt == 4'd1) state_nxt = S_CHECK;
      end
      S_CHECK: begin
        if (abort)                   state_nxt = S_IDLE;
        else if (vec_out == LAST_VEC) state_nxt = S_DONE;
        else                         state_nxt = vec_entry_state();
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Status outputs decoded straight from the registered state.
  always_comb begin
    busy = running;
    done = (state == S_DONE);
    pass = (state == S_DONE) && (err_count == '0);
  end

  // Vector, hold counter and error bookkeeping; aborted sweeps keep their partial error results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_out         <= '0;
      hold_cnt        <= '0;
      err_count       <= '0;
      first_err_idx   <= '0;
      first_err_valid <= 1'b0;
    end else if (go) begin
      vec_out         <= '0;
      hold_cnt        <= SETTLE_C;
      err_count       <= '0;
      first_err_idx   <= '0;
      first_err_valid <= 1'b0;
    end else if (running && abort) begin
      vec_out <= '0;
    end else if (state == S_WAIT) begin
      hold_cnt <= hold_cnt - 4'd1;
    end else if (state == S_CHECK) begin
      if (mismatch) begin
        err_count <= err_count + (N_IN+1)'(1);
        if (!first_err_valid) begin
          first_err_idx   <= vec_out;
          first_err_valid <= 1'b1;
        end
      end
      if (vec_out == LAST_VEC) vec_out <= '0;
      else                     vec_out <= vec_out + 1'b1;
      hold_cnt <= SETTLE_C;
    end
  end

endmodule

// File: tb/tb_kmap_sweep_ctrl.sv
// tb/tb_kmap_sweep_ctrl.sv - directed table-driven bench for kmap_sweep_ctrl
module tb_kmap_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       start1 = 1'b0;
  int         mode = 0;

  logic [2:0] vec0, vec1;
  logic       dout0, dout1;
  logic       busy0, done0, pass0, busy1, done1, pass1;
  logic [3:0] err0, err1;
  logic [2:0] idx0, idx1;
  logic       val0, val1;
  logic       f0_q, f1_q;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  kmap_sweep_ctrl #(.N_IN(3), .SETTLE(0), .REF_TABLE(8'hFE)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .vec_out(vec0), .dut_out(dout0), .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .first_err_idx(idx0), .first_err_valid(val0)
  );

  kmap_sweep_ctrl #(.N_IN(3), .SETTLE(1), .REF_TABLE(8'hFE)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(1'b0),
    .vec_out(vec1), .dut_out(dout1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .first_err_idx(idx1), .first_err_valid(val1)
  );

  // Registered copies of a|b|c, one per controller.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f0_q <= 1'b0;
      f1_q <= 1'b0;
    end else begin
      f0_q <= |vec0;
      f1_q <= |vec1;
    end
  end

  // Function under test for u0: 0 a|b|c, 1 stuck-at-0, 2 inverted, 3 registered.
  always_comb begin
    case (mode)
      1:       dout0 = 1'b0;
      2:       dout0 = ~(|vec0);
      3:       dout0 = f0_q;
      default: dout0 = |vec0;
    endcase
  end
  assign dout1 = f1_q;

  typedef struct {
    int mode;
    int err;
    int idx;
    int valid;
    int pass;
    int cycles;
  } vec_t;

  vec_t tbl[4];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Pulse start, then step edges until done; optional retrigger/abort at given edge counts.
  task automatic sweep(input int retrig_at, input int abort_at, output int n);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    chk("busy_after_start", int'(busy0), 1);
    while (!done0 && n < 100) begin
      if (n == retrig_at) start = 1'b1;
      if (n == abort_at)  abort = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n++;
      if (abort_at >= 0 && n == abort_at + 1) begin
        abort = 1'b0;
        break;
      end
      if (!done0) chk("vec_step", int'(vec0), n);
    end
  endtask

  initial begin
    int n;
    tbl[0] = '{mode: 0, err: 0, idx: 0, valid: 0, pass: 1, cycles: 8};
    tbl[1] = '{mode: 1, err: 7, idx: 1, valid: 1, pass: 0, cycles: 8};
    tbl[2] = '{mode: 2, err: 8, idx: 0, valid: 1, pass: 0, cycles: 8};
    tbl[3] = '{mode: 3, err: 1, idx: 1, valid: 1, pass: 0, cycles: 8};

    #12;
    chk("rst_vec",   int'(vec0),  0);
    chk("rst_busy",  int'(busy0), 0);
    chk("rst_done",  int'(done0), 0);
    chk("rst_pass",  int'(pass0), 0);
    chk("rst_err",   int'(err0),  0);
    chk("rst_valid", int'(val0),  0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++) begin
      mode = tbl[i].mode;
      @(posedge clk); #1;
      sweep(-1, -1, n);
      chk("tbl_cycles", n,            tbl[i].cycles);
      chk("tbl_done",   int'(done0),  1);
      chk("tbl_busy",   int'(busy0),  0);
      chk("tbl_err",    int'(err0),   tbl[i].err);
      chk("tbl_idx",    int'(idx0),   tbl[i].idx);
      chk("tbl_valid",  int'(val0),   tbl[i].valid);
      chk("tbl_pass",   int'(pass0),  tbl[i].pass);
      chk("tbl_vec_end", int'(vec0),  0);
      @(posedge clk); #1;
      chk("tbl_done_hold", int'(done0), 1);
    end

    // abort in DONE (even together with start) leaves DONE untouched
    abort = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    start = 1'b0;
    chk("abort_in_done", int'(done0), 1);
    chk("abort_in_done_err", int'(err0), 1);

    // registered function with one settle cycle
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    n = 0;
    while (!done1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("settle1_cycles", n, 16);
    chk("settle1_pass",   int'(pass1), 1);
    chk("settle1_err",    int'(err1),  0);

    // start re-asserted mid-sweep is ignored
    mode = 0;
    sweep(3, -1, n);
    chk("retrig_cycles", n, 8);
    chk("retrig_pass",   int'(pass0), 1);

    // abort after four checked vectors of a stuck-at-0 function
    mode = 1;
    sweep(-1, 4, n);
    chk("abort_busy",  int'(busy0), 0);
    chk("abort_done",  int'(done0), 0);
    chk("abort_err",   int'(err0),  3);
    chk("abort_idx",   int'(idx0),  1);
    chk("abort_valid", int'(val0),  1);
    chk("abort_vec",   int'(vec0),  0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("restart_err",   int'(err0), 0);
    chk("restart_valid", int'(val0), 0);
    n = 0;
    while (!done0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("restart_cycles", n, 8);
    chk("restart_err_end", int'(err0), 7);

    // asynchronous reset between edges mid-sweep
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    #3;
    rst_n = 1'b0;
    #1;
    chk("areset_vec",   int'(vec0),  0);
    chk("areset_busy",  int'(busy0), 0);
    chk("areset_done",  int'(done0), 0);
    chk("areset_err",   int'(err0),  0);
    chk("areset_valid", int'(val0),  0);
    chk("areset_idx",   int'(idx0),  0);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    mode = 0;
    sweep(-1, -1, n);
    chk("post_reset_cycles", n, 8);
    chk("post_reset_pass",   int'(pass0), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
